scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 19 +
 rtl/scan_sequencer_if.sv | 22 ++
 rtl/scan_dwell_cnt.sv | 29 ++
 rtl/scan_sequencer.sv | 96 +++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and widths for the scan sequencer slice.
package scan_pkg;

  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Next digit in the frame, wrapping after the captured last digit.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel,
                                                input logic [SEL_W-1:0] last);
    return (sel == last) ? '0 : SEL_W'(sel + 1'b1);
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the scan sequencer.
interface scan_sequencer_if;

  logic                      start;
  logic                      stop;
  logic [scan_pkg::SEL_W-1:0] last_sel;
  logic [scan_pkg::SEL_W-1:0] sel;
  logic                      en;
  logic                      busy;
  logic                      frame_done;

  modport master (
    output start, stop, last_sel,
    input  sel, en, busy, frame_done
  );

  modport slave (
    input  start, stop, last_sel,
    output sel, en, busy, frame_done
  );

endinterface

// File: rtl/scan_dwell_cnt.sv
// Dwell counter: counts while inc is high, self-wraps at DWELL-1, tc flags the last count.
module scan_dwell_cnt
  import scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/scan_sequencer.sv
// Multiplexed-display scan sequencer: steps sel 0..last_sel, holding each digit DWELL cycles.
// Define SCAN_SEQUENCER_BLANK_EN to insert a one-cycle blanking gap (en=0) after each dwell.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  scan_sequencer_if.slave   bus
);

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic             en_q;
  logic             busy_q;
  logic             done_q;
  logic             dwell_tc;

  // The counter runs only in SCAN and is parked at zero everywhere else.
  scan_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (state != SCAN),
    .inc (state == SCAN),
    .tc  (dwell_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      last_q <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state  <= SCAN;
            sel_q  <= '0;
            last_q <= bus.last_sel;
            en_q   <= 1'b1;
            busy_q <= 1'b1;
          end
        end

        SCAN: begin
          if (bus.stop) begin
            state  <= IDLE;
            sel_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end else if (dwell_tc) begin
            sel_q  <= next_sel(sel_q, last_q);
            done_q <= (sel_q == last_q);
`ifdef SCAN_SEQUENCER_BLANK_EN
            state  <= BLANK;
            en_q   <= 1'b0;
`endif
          end
        end

`ifdef SCAN_SEQUENCER_BLANK_EN
        BLANK: begin
          if (bus.stop) begin
            state  <= IDLE;
            sel_q  <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
          end else begin
            state  <= SCAN;
            en_q   <= 1'b1;
          end
        end
`endif

        default: begin
          state  <= IDLE;
          sel_q  <= '0;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
